// File: rtl/fp_add_pkg.sv
// Shared constants and alignment FSM state type for the FP adder datapath.
package fp_add_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned GRS_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

endpackage

// File: rtl/sticky_shift_step.sv
// One combinational alignment step: right-shift {mant,g,r} by amount_i and
// fold every bit that falls off the bottom into sticky.
module sticky_shift_step #(
  parameter int unsigned W  = 26,
  parameter int unsigned KW = 3
) (
  input  logic [W-1:0]  bits_i,
  input  logic          sticky_i,
  input  logic [KW-1:0] amount_i,
  output logic [W-1:0]  bits_o,
  output logic          sticky_o
);

  logic [W-1:0] lost_mask;

  always_comb begin
    lost_mask = ~({W{1'b1}} << amount_i);
    bits_o    = bits_i >> amount_i;
    sticky_o  = sticky_i | (|(bits_i & lost_mask));
  end

endmodule

// File: rtl/mantissa_align_shifter.sv
// FP adder alignment stage: multi-cycle right shift of the smaller mantissa by the
// exponent difference, collecting guard/round/sticky, with valid/ready on both sides.
module mantissa_align_shifter #(
  parameter int unsigned MANT_W = fp_add_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_add_pkg::EXP_W,
  parameter int unsigned STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_diff,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              guard,
  output logic              round,
  output logic              sticky
);
  import fp_add_pkg::*;

  localparam int unsigned W  = MANT_W + GRS_W - 1;
  localparam int unsigned KW = $clog2(STEP + 1);
  // Beyond this every mantissa bit lands in sticky, so skip the iterative shift.
  localparam logic [EXP_W:0] FAST_D = (EXP_W + 1)'(MANT_W + 2);

  align_state_t     state_q, state_d;
  logic [EXP_W-1:0] rem_q, rem_d;
  logic [W-1:0]     work_q, work_d;
  logic             sticky_q, sticky_d;
  logic [EXP_W-1:0] exp_q, exp_d;

  logic [KW-1:0]    k;
  logic [W-1:0]     step_bits;
  logic             step_sticky;

  always_comb begin
    k = (rem_q < EXP_W'(STEP)) ? rem_q[KW-1:0] : KW'(STEP);
  end

  sticky_shift_step #(
    .W  (W),
    .KW (KW)
  ) u_step (
    .bits_i   (work_q),
    .sticky_i (sticky_q),
    .amount_i (k),
    .bits_o   (step_bits),
    .sticky_o (step_sticky)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    exp_d    = exp_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d    = exp_in;
          work_d   = {mant_in, 2'b00};
          sticky_d = 1'b0;
          rem_d    = exp_diff;
          if (exp_diff == '0) begin
            state_d = DONE;
          end else if ({1'b0, exp_diff} >= FAST_D) begin
            work_d   = '0;
            sticky_d = |mant_in;
            rem_d    = '0;
            state_d  = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d   = step_bits;
        sticky_d = step_sticky;
        rem_d    = rem_q - EXP_W'(k);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      work_q   <= work_d;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    exp_out   = exp_q;
    mant_out  = work_q[W-1:2];
    guard     = work_q[1];
    round     = work_q[0];
    sticky    = sticky_q;
  end

endmodule

// File: tb/tb_mantissa_align_shifter.sv
// Self-checking bench for mantissa_align_shifter: scoreboard of reference results,
// latency, hold-stability and mid-operation reset checks.
module tb_mantissa_align_shifter;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int STEP   = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  exp_diff;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] mant_in;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;
  logic              guard;
  logic              round;
  logic              sticky;

  mantissa_align_shifter #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W),
    .STEP   (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_diff  (exp_diff),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .guard     (guard),
    .round     (round),
    .sticky    (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic              g;
    logic              r;
    logic              s;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int d, input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e);
    exp_t x;
    x.e = e;
    x.m = (d >= MANT_W) ? '0 : m >> d;
    x.g = (d >= 1 && d - 1 < MANT_W) ? m[d-1] : 1'b0;
    x.r = (d >= 2 && d - 2 < MANT_W) ? m[d-2] : 1'b0;
    x.s = 1'b0;
    for (int i = 0; i < MANT_W; i++) if (d >= 3 && i <= d - 3) x.s |= m[i];
    x.lat = (d == 0 || d >= MANT_W + 2) ? 1 : 1 + (d + STEP - 1) / STEP;
    return x;
  endfunction

  // Drive one op, wait for its result, optionally stall out_ready, then handshake.
  task automatic do_op(input int d, input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                       input int hold);
    exp_t want;
    int   edges;
    logic [MANT_W-1:0] m_cap;
    logic [EXP_W-1:0]  e_cap;
    logic [2:0]        grs_cap;
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    exp_diff = EXP_W'(d);
    mant_in  = m;
    exp_in   = e;
    sb.push_back(model(d, m, e));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1'b1);
      return;
    end
    want = sb.pop_front();
    chk($sformatf("latency_d%0d", d), edges, want.lat);
    chk("in_ready_busy", in_ready, 1'b0);
    m_cap = mant_out;
    e_cap = exp_out;
    grs_cap = {guard, round, sticky};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_mant", mant_out, m_cap);
      chk("hold_exp", exp_out, e_cap);
      chk("hold_grs", {guard, round, sticky}, grs_cap);
    end
    chk($sformatf("mant_d%0d", d), mant_out, want.m);
    chk($sformatf("exp_d%0d", d), exp_out, want.e);
    chk($sformatf("grs_d%0d", d), {guard, round, sticky}, {want.g, want.r, want.s});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_cleared", out_valid, 1'b0);
    chk("in_ready_after", in_ready, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_diff  = '0;
    exp_in    = '0;
    mant_in   = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {exp_out, mant_out, guard, round, sticky}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 24'hC00000, 8'h85, 0);
    do_op(5, 24'h800001, 8'h10, 0);
    do_op(2, 24'h000003, 8'h20, 0);
    do_op(30, 24'h000001, 8'h30, 0);
    do_op(26, 24'h800000, 8'h31, 0);
    do_op(25, 24'hFFFFFF, 8'h32, 0);
    do_op(8, 24'hABCDEF, 8'h40, 3);
    do_op(7, 24'h123456, 8'h41, 0);

    // Reset in the middle of a long shift discards the op.
    @(negedge clk);
    in_valid = 1'b1;
    exp_diff = 8'd20;
    mant_in  = 24'hFFFFFF;
    exp_in   = 8'h77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_shift_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_outputs", {exp_out, mant_out, guard, round, sticky}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 24'h000001, 8'h55, 0);

    for (int n = 0; n < 12; n++) begin
      do_op(int'($urandom_range(0, 40)), MANT_W'($urandom), EXP_W'($urandom),
            int'($urandom_range(0, 2)));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
